// File: rtl/uart_response_tx.sv
// -----------------------------------------------------------------------------
// uart_response_tx
//   Transmit side of the host-link UART bridge. A 16-bit read-response word is
//   encoded as the 7-byte ASCII message "D<hhhh>\r\n" (uppercase hex) and sent
//   as UART frames on tx: start bit, d0..d7 LSB first, stop bit. Bytes follow
//   each other with no idle gap.
//
//   Optional feature macro: UART_PARITY_EN
//     defined   : an even-parity bit (XOR of d0..d7) sits between d7 and stop,
//                 giving 11 bits per byte and an extra PARITY state.
//     undefined : plain 8N1, no PARITY state.
//
//   All outputs come straight from flops, so tx is glitch-free and never X
//   after reset. ready_o is high only in IDLE; busy_o is its complement.
// -----------------------------------------------------------------------------
module uart_response_tx #(
   parameter int CLOCKS_PER_BAUD = 868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        tx,
   output logic        busy_o
);

   // Baud counter width; a 1-bit counter is the floor for the minimum divisor.
   localparam int BAUD_W = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
   localparam logic [2:0]        LAST_BYTE = 3'd6;
   localparam logic [2:0]        LAST_BIT  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } state_t;

   // Map one nibble to its uppercase ASCII hex character.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] chr;
      if (nib < 4'd10) begin
         chr = 8'h30 + {4'h0, nib};
      end else begin
         chr = 8'h41 + ({4'h0, nib} - 8'd10);
      end
      return chr;
   endfunction

   // Select the message byte at position idx for the latched word.
   function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [15:0] word);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'h44;
         3'd1:    b = hex_ascii(word[15:12]);
         3'd2:    b = hex_ascii(word[11:8]);
         3'd3:    b = hex_ascii(word[7:4]);
         3'd4:    b = hex_ascii(word[3:0]);
         3'd5:    b = 8'h0D;
         3'd6:    b = 8'h0A;
         default: b = 8'h0A;
      endcase
      return b;
   endfunction

   // Even parity over a data byte: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [2:0]          byte_idx_q, byte_idx_d;
   logic [15:0]         data_q, data_d;
   logic                tx_q, tx_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;

   logic [7:0]          cur_byte_s;
   logic                baud_done_s;
   logic [2:0]          next_bit_s;

   assign cur_byte_s  = msg_byte(byte_idx_q, data_q);
   assign baud_done_s = (baud_cnt_q == BAUD_LAST);
   assign next_bit_s  = bit_idx_q + 3'd1;

   // Next-state, counter and registered-output logic; tx_d is the level for the coming cycle.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      data_d     = data_q;
      tx_d       = tx_q;
      ready_d    = ready_q;
      busy_d     = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               // Word accepted: start bit of byte 0 goes out on the very next cycle.
               data_d     = data_i;
               state_d    = ST_START;
               baud_cnt_d = {BAUD_W{1'b0}};
               bit_idx_d  = 3'd0;
               byte_idx_d = 3'd0;
               tx_d       = 1'b0;
               ready_d    = 1'b0;
               busy_d     = 1'b1;
            end else begin
               baud_cnt_d = {BAUD_W{1'b0}};
               tx_d       = 1'b1;
               ready_d    = 1'b1;
               busy_d     = 1'b0;
            end
         end

         ST_START: begin
            if (baud_done_s) begin
               baud_cnt_d = {BAUD_W{1'b0}};
               bit_idx_d  = 3'd0;
               state_d    = ST_DATA;
               tx_d       = cur_byte_s[0];
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BAUD_W-1){1'b0}}, 1'b1};
            end
         end

         ST_DATA: begin
            if (baud_done_s) begin
               baud_cnt_d = {BAUD_W{1'b0}};
               if (bit_idx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = even_parity(cur_byte_s);
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = next_bit_s;
                  tx_d      = cur_byte_s[next_bit_s];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BAUD_W-1){1'b0}}, 1'b1};
            end
         end

`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (baud_done_s) begin
               baud_cnt_d = {BAUD_W{1'b0}};
               state_d    = ST_STOP;
               tx_d       = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BAUD_W-1){1'b0}}, 1'b1};
            end
         end
`endif

         ST_STOP: begin
            if (baud_done_s) begin
               baud_cnt_d = {BAUD_W{1'b0}};
               bit_idx_d  = 3'd0;
               if (byte_idx_q < LAST_BYTE) begin
                  // Next byte's start bit follows the stop bit with no gap.
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = ST_START;
                  tx_d       = 1'b0;
               end else begin
                  byte_idx_d = 3'd0;
                  state_d    = ST_IDLE;
                  tx_d       = 1'b1;
                  ready_d    = 1'b1;
                  busy_d     = 1'b0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BAUD_W-1){1'b0}}, 1'b1};
            end
         end

         default: begin
            // Unreachable encodings recover to a clean idle line.
            state_d    = ST_IDLE;
            baud_cnt_d = {BAUD_W{1'b0}};
            bit_idx_d  = 3'd0;
            byte_idx_d = 3'd0;
            tx_d       = 1'b1;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State, counters, latched word and output flops; reset abandons any message in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= {BAUD_W{1'b0}};
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 3'd0;
         data_q     <= 16'h0000;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         data_q     <= data_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign ready_o = ready_q;
   assign busy_o  = busy_q;

endmodule
